// File: rtl/command_decoder_pkg.sv
// Shared definitions for the command register bank: word field widths,
// assembler states and the address of each channel.
package command_decoder_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int PAYLOAD_WIDTH = 4;
  localparam int ADDR_WIDTH    = WORD_WIDTH - PAYLOAD_WIDTH;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_e;

  function automatic logic [ADDR_WIDTH-1:0] channel_address(
    input logic [ADDR_WIDTH-1:0] base,
    input int                    idx
  );
    return base + ADDR_WIDTH'(idx);
  endfunction

endpackage

// File: rtl/command_register_bank_if.sv
// Command word input and per-channel command outputs of the register bank.
interface command_register_bank_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8
);

  logic                               CommandFifoReadEn;
  logic [15:0]                        COMMAND_WORD;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] CommandOut;
  logic [NUM_CHANNELS-1:0]            CommandValid;
  logic                               AssemblyError;

  modport master (
    output CommandFifoReadEn,
    output COMMAND_WORD,
    input  CommandOut,
    input  CommandValid,
    input  AssemblyError
  );

  modport slave (
    input  CommandFifoReadEn,
    input  COMMAND_WORD,
    output CommandOut,
    output CommandValid,
    output AssemblyError
  );

endinterface

// File: rtl/command_channel.sv
// One channel output register: holds the committed value (level mode) or
// shows it for PULSE_CYCLES clocks before falling back to the default (pulse mode).
module command_channel #(
  parameter int                    DATA_WIDTH    = 8,
  parameter bit                    PULSE_MODE    = 1'b0,
  parameter int                    PULSE_CYCLES  = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '1
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] commit_data,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] value_r;
  logic [7:0]            pulse_cnt_r;
  logic                  valid_r;

  // Value register, pulse countdown and commit strobe; a commit always restarts the pulse.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      value_r     <= DEFAULT_VALUE;
      pulse_cnt_r <= 8'd0;
      valid_r     <= 1'b0;
    end else begin
      valid_r <= commit;
      if (commit) begin
        value_r     <= commit_data;
        pulse_cnt_r <= PULSE_MODE ? 8'(PULSE_CYCLES) : 8'd0;
      end else if (PULSE_MODE && (pulse_cnt_r == 8'd1)) begin
        value_r     <= DEFAULT_VALUE;
        pulse_cnt_r <= 8'd0;
      end else if (pulse_cnt_r != 8'd0) begin
        value_r     <= value_r;
        pulse_cnt_r <= pulse_cnt_r - 8'd1;
      end else begin
        value_r     <= value_r;
        pulse_cnt_r <= pulse_cnt_r;
      end
    end
  end

  assign value = value_r;
  assign valid = valid_r;

endmodule

// File: rtl/command_register_bank.sv
// Assembles multi-nibble commands from addressed 16-bit words and commits
// them to a bank of level or pulse output channels.
module command_register_bank
  import command_decoder_pkg::*;
#(
  parameter int                       NUM_CHANNELS   = 4,
  parameter logic [11:0]              BASE_ADDRESS   = 12'hA00,
  parameter int                       NIBBLES        = 2,
  parameter logic [NUM_CHANNELS-1:0]  PULSE_MASK     = '0,
  parameter int                       PULSE_CYCLES   = 1,
  parameter int                       TIMEOUT_CYCLES = 1000,
  parameter logic [NUM_CHANNELS*16-1:0] DEFAULT_VALUE = '1
) (
  input  logic                    Clk,
  input  logic                    reset_n,
  command_register_bank_if.slave  bus
);

  localparam int DATA_WIDTH = 4 * NIBBLES;

  asm_state_e                         state_r, state_n;
  logic [2:0]                         count_r, count_n;
  logic [2:0]                         chan_r, chan_n;
  logic [2:0]                         idx_s;
  logic [DATA_WIDTH-1:0]              data_r, data_n;
  logic [DATA_WIDTH-1:0]              nibble_ext_s, shifted_s;
  logic [15:0]                        timer_r, timer_n;
  logic                               err_r, err_n;
  logic                               match_s, word_commit_s;
  logic [NUM_CHANNELS-1:0]            commit_s;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_s;
  logic [NUM_CHANNELS-1:0]            valid_s;

  // Address decode: which channel, if any, the current word belongs to.
  always_comb begin
    match_s = 1'b0;
    idx_s   = 3'd0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (bus.CommandFifoReadEn &&
          (bus.COMMAND_WORD[WORD_WIDTH-1:PAYLOAD_WIDTH] == channel_address(BASE_ADDRESS, i))) begin
        match_s = 1'b1;
        idx_s   = 3'(i);
      end else begin
        match_s = match_s;
      end
    end
  end

  // Shifting left from the LSB leaves the first nibble in the top position.
  assign nibble_ext_s = DATA_WIDTH'(bus.COMMAND_WORD[PAYLOAD_WIDTH-1:0]);
  assign shifted_s    = (data_r << 4) | nibble_ext_s;

  // Assembler next-state: collect, commit, interleave restart and timeout.
  always_comb begin
    state_n       = state_r;
    count_n       = count_r;
    chan_n        = chan_r;
    data_n        = data_r;
    timer_n       = timer_r;
    err_n         = 1'b0;
    word_commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        timer_n = 16'd0;
        if (match_s) begin
          if (NIBBLES == 1) begin
            word_commit_s = 1'b1;
          end else begin
            data_n  = nibble_ext_s;
            chan_n  = idx_s;
            count_n = 3'd1;
            state_n = COLLECT;
          end
        end else begin
          count_n = 3'd0;
        end
      end
      COLLECT: begin
        if (match_s && (idx_s == chan_r)) begin
          timer_n = 16'd0;
          if ((count_r + 3'd1) == 3'(NIBBLES)) begin
            word_commit_s = 1'b1;
            count_n       = 3'd0;
            state_n       = IDLE;
          end else begin
            data_n  = shifted_s;
            count_n = count_r + 3'd1;
          end
        end else if (match_s) begin
          err_n   = 1'b1;
          data_n  = nibble_ext_s;
          chan_n  = idx_s;
          count_n = 3'd1;
          timer_n = 16'd0;
        end else if (timer_r == 16'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          count_n = 3'd0;
          timer_n = 16'd0;
          state_n = IDLE;
        end else begin
          timer_n = timer_r + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 3'd0;
        timer_n = 16'd0;
      end
    endcase
  end

  assign commit_s = word_commit_s ? (NUM_CHANNELS'(1) << idx_s) : '0;

  // Assembler state registers.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      count_r <= 3'd0;
      chan_r  <= 3'd0;
      data_r  <= '0;
      timer_r <= 16'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      chan_r  <= chan_n;
      data_r  <= data_n;
      timer_r <= timer_n;
      err_r   <= err_n;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    command_channel #(
      .DATA_WIDTH    (DATA_WIDTH),
      .PULSE_MODE    (PULSE_MASK[g]),
      .PULSE_CYCLES  (PULSE_CYCLES),
      .DEFAULT_VALUE (DEFAULT_VALUE[16*g +: DATA_WIDTH])
    ) u_ch (
      .Clk         (Clk),
      .reset_n     (reset_n),
      .commit      (commit_s[g]),
      .commit_data (shifted_s),
      .value       (out_s[DATA_WIDTH*g +: DATA_WIDTH]),
      .valid       (valid_s[g])
    );
  end

  assign bus.CommandOut    = out_s;
  assign bus.CommandValid  = valid_s;
  assign bus.AssemblyError = err_r;

endmodule

// File: tb/tb_command_register_bank.sv
// Directed checks of the command register bank: 2-nibble commands, channel 2
// in pulse mode for 3 clocks, timeout of 10 clocks.
module tb_command_register_bank;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  command_register_bank_if #(.NUM_CHANNELS(4), .DATA_WIDTH(8)) bus ();

  command_register_bank #(
    .NUM_CHANNELS   (4),
    .BASE_ADDRESS   (12'hA00),
    .NIBBLES        (2),
    .PULSE_MASK     (4'b0100),
    .PULSE_CYCLES   (3),
    .TIMEOUT_CYCLES (10),
    .DEFAULT_VALUE  ({64{1'b1}})
  ) dut (
    .Clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: present one word, return at the next falling edge.
  task automatic step(input logic en, input logic [15:0] w);
    bus.CommandFifoReadEn = en;
    bus.COMMAND_WORD      = w;
    @(negedge clk);
    bus.CommandFifoReadEn = 1'b0;
    bus.COMMAND_WORD      = 16'h0000;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.CommandFifoReadEn = 1'b0;
    bus.COMMAND_WORD      = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.CommandOut !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_out got %h expected %h", bus.CommandOut, 32'hFFFF_FFFF);
    end
    checks++;
    if (bus.CommandValid !== 4'b0000 || bus.AssemblyError !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got %b/%b expected 0000/0", bus.CommandValid, bus.AssemblyError);
    end
    reset_n = 1'b1;
    step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
    checks++;
    if (bus.CommandValid !== 4'b0000 || bus.CommandOut !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_release got %b/%h expected 0000/ffffffff", bus.CommandValid, bus.CommandOut);
    end
  endtask

  task automatic test_level();
    step(1'b1, 16'hA015);
    checks++;
    if (bus.CommandValid !== 4'b0000 || bus.CommandOut[15:8] !== 8'hFF) begin
      errors++; $display("FAIL level_first got %b/%h expected 0000/ff", bus.CommandValid, bus.CommandOut[15:8]);
    end
    step(1'b1, 16'hA01C);
    checks++;
    if (bus.CommandOut[15:8] !== 8'h5C || bus.CommandValid !== 4'b0010) begin
      errors++; $display("FAIL level_commit got %h/%b expected 5c/0010", bus.CommandOut[15:8], bus.CommandValid);
    end
    step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
    checks++;
    if (bus.CommandOut[15:8] !== 8'h5C || bus.CommandValid !== 4'b0000) begin
      errors++; $display("FAIL level_hold got %h/%b expected 5c/0000", bus.CommandOut[15:8], bus.CommandValid);
    end
  endtask

  task automatic test_pulse();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h7E, 8'h7E, 8'h7E, 8'hFF};
    step(1'b1, 16'hA027);
    step(1'b1, 16'hA02E);
    checks++;
    if (bus.CommandValid !== 4'b0100) begin
      errors++; $display("FAIL pulse_valid got %b expected 0100", bus.CommandValid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.CommandOut[23:16] !== exp_seq[i]) begin
        errors++; $display("FAIL pulse_cycle%0d got %h expected %h", i + 1, bus.CommandOut[23:16], exp_seq[i]);
      end
      step(1'b0, 16'h0000);
    end
    // Recommit lands while the second pulse cycle is showing.
    step(1'b1, 16'hA027);
    step(1'b1, 16'hA02E);
    step(1'b1, 16'hA021);
    checks++;
    if (bus.CommandOut[23:16] !== 8'h7E) begin
      errors++; $display("FAIL pulse_before_recommit got %h expected 7e", bus.CommandOut[23:16]);
    end
    step(1'b1, 16'hA02A);
    exp_seq = '{8'h1A, 8'h1A, 8'h1A, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.CommandOut[23:16] !== exp_seq[i]) begin
        errors++; $display("FAIL recommit_cycle%0d got %h expected %h", i + 1, bus.CommandOut[23:16], exp_seq[i]);
      end
      step(1'b0, 16'h0000);
    end
    checks++;
    if (bus.CommandOut[15:8] !== 8'h5C) begin
      errors++; $display("FAIL pulse_ch1_untouched got %h expected 5c", bus.CommandOut[15:8]);
    end
  endtask

  task automatic test_interleave();
    step(1'b1, 16'hA013);
    step(1'b1, 16'hA024);
    checks++;
    if (bus.AssemblyError !== 1'b1 || bus.CommandValid !== 4'b0000 || bus.CommandOut[15:8] !== 8'h5C) begin
      errors++; $display("FAIL interleave_error got %b/%b/%h expected 1/0000/5c",
                         bus.AssemblyError, bus.CommandValid, bus.CommandOut[15:8]);
    end
    step(1'b1, 16'hA025);
    checks++;
    if (bus.AssemblyError !== 1'b0 || bus.CommandValid !== 4'b0100 || bus.CommandOut[23:16] !== 8'h45) begin
      errors++; $display("FAIL interleave_commit got %b/%b/%h expected 0/0100/45",
                         bus.AssemblyError, bus.CommandValid, bus.CommandOut[23:16]);
    end
    repeat (4) step(1'b0, 16'h0000);
  endtask

  task automatic test_timeout();
    step(1'b1, 16'hA013);
    repeat (9) step(1'b0, 16'h0000);
    checks++;
    if (bus.AssemblyError !== 1'b0) begin
      errors++; $display("FAIL timeout_early got %b expected 0", bus.AssemblyError);
    end
    step(1'b0, 16'h0000);
    checks++;
    if (bus.AssemblyError !== 1'b1 || bus.CommandValid !== 4'b0000 || bus.CommandOut[15:8] !== 8'h5C) begin
      errors++; $display("FAIL timeout_fire got %b/%b/%h expected 1/0000/5c",
                         bus.AssemblyError, bus.CommandValid, bus.CommandOut[15:8]);
    end
    step(1'b0, 16'h0000);
    checks++;
    if (bus.AssemblyError !== 1'b0) begin
      errors++; $display("FAIL timeout_strobe_len got %b expected 0", bus.AssemblyError);
    end
    step(1'b1, 16'hA013);
    repeat (9) step(1'b0, 16'h0000);
    step(1'b1, 16'hA01D);
    checks++;
    if (bus.AssemblyError !== 1'b0 || bus.CommandValid !== 4'b0010 || bus.CommandOut[15:8] !== 8'h3D) begin
      errors++; $display("FAIL timeout_word_wins got %b/%b/%h expected 0/0010/3d",
                         bus.AssemblyError, bus.CommandValid, bus.CommandOut[15:8]);
    end
    step(1'b0, 16'h0000);
  endtask

  task automatic test_nonmatch();
    step(1'b1, 16'hA016);
    step(1'b1, 16'hB015);
    checks++;
    if (bus.AssemblyError !== 1'b0 || bus.CommandValid !== 4'b0000) begin
      errors++; $display("FAIL nonmatch_ignored got %b/%b expected 0/0000", bus.AssemblyError, bus.CommandValid);
    end
    step(1'b1, 16'hA01A);
    checks++;
    if (bus.CommandOut[15:8] !== 8'h6A || bus.CommandValid !== 4'b0010) begin
      errors++; $display("FAIL nonmatch_commit got %h/%b expected 6a/0010", bus.CommandOut[15:8], bus.CommandValid);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'hA031);
    step(1'b1, 16'hA032);
    checks++;
    if (bus.CommandOut[31:24] !== 8'h12 || bus.CommandValid !== 4'b1000) begin
      errors++; $display("FAIL b2b_ch3 got %h/%b expected 12/1000", bus.CommandOut[31:24], bus.CommandValid);
    end
    step(1'b1, 16'hA00B);
    step(1'b1, 16'hA00C);
    checks++;
    if (bus.CommandOut[7:0] !== 8'hBC || bus.CommandValid !== 4'b0001 || bus.CommandOut[15:8] !== 8'h6A) begin
      errors++; $display("FAIL b2b_ch0 got %h/%b/%h expected bc/0001/6a",
                         bus.CommandOut[7:0], bus.CommandValid, bus.CommandOut[15:8]);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 16'hA027);
    step(1'b1, 16'hA02E);
    step(1'b1, 16'hA014);
    checks++;
    if (bus.CommandOut[23:16] !== 8'h7E) begin
      errors++; $display("FAIL mid_pulse_active got %h expected 7e", bus.CommandOut[23:16]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.CommandOut !== 32'hFFFF_FFFF || bus.CommandValid !== 4'b0000 || bus.AssemblyError !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h/%b/%b expected ffffffff/0000/0",
                         bus.CommandOut, bus.CommandValid, bus.AssemblyError);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 16'h0000);
    step(1'b1, 16'hA01B);
    checks++;
    if (bus.CommandValid !== 4'b0000 || bus.CommandOut[15:8] !== 8'hFF) begin
      errors++; $display("FAIL mid_partial_discarded got %b/%h expected 0000/ff", bus.CommandValid, bus.CommandOut[15:8]);
    end
    step(1'b1, 16'hA01C);
    checks++;
    if (bus.CommandValid !== 4'b0010 || bus.CommandOut[15:8] !== 8'hBC) begin
      errors++; $display("FAIL mid_after_reset got %b/%h expected 0010/bc", bus.CommandValid, bus.CommandOut[15:8]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_level();
    test_pulse();
    test_interleave();
    test_timeout();
    test_nonmatch();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/command_register_bank.md
COMMAND_REGISTER_BANK -- requirements
Module: command_register_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of command channels (legal 1..8).
REQ-002 SHALL have parameter BASE_ADDRESS, 12 bits, default 12'hA00; channel i answers to address BASE_ADDRESS+i.
REQ-003 SHALL have parameter NIBBLES, default 2, 4-bit words per command (legal 1..4); DATA_WIDTH = 4*NIBBLES.
REQ-004 SHALL have parameter PULSE_MASK, NUM_CHANNELS bits, default 0; bit i=1 puts channel i in pulse mode, 0 in level mode.
REQ-005 SHALL have parameter PULSE_CYCLES, default 1, pulse length in clocks (legal 1..255).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000, max clocks between words of one command (legal 2..65535).
REQ-007 SHALL have parameter DEFAULT_VALUE, NUM_CHANNELS*16 bits, default all ones; channel i default = bits [16i+DATA_WIDTH-1:16i].
REQ-008 Clk  input  1  sole clock, all logic on rising edge.
REQ-009 reset_n  input  1  asynchronous, active-low reset.
REQ-010 CommandFifoReadEn  input  1  COMMAND_WORD valid this cycle.
REQ-011 COMMAND_WORD  input  16  [15:4] address, [3:0] payload nibble.
REQ-012 CommandOut  output  NUM_CHANNELS*DATA_WIDTH  channel i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
REQ-013 CommandValid  output  NUM_CHANNELS  one-cycle strobe, bit i high the cycle channel i's new value first appears.
REQ-014 AssemblyError  output  1  one-cycle strobe on aborted assembly.

Function
REQ-015 A word SHALL match channel i only when CommandFifoReadEn=1 and COMMAND_WORD[15:4]=BASE_ADDRESS+i; non-matching words SHALL be ignored with no state change.
REQ-016 One shared assembler SHALL have states IDLE and COLLECT, with nibble count and captured channel index.
REQ-017 IDLE + matching word: if NIBBLES=1 commit immediately; else store nibble, latch channel, count=1, enter COLLECT.
REQ-018 Nibbles SHALL be assembled MSB first: first word supplies bits [DATA_WIDTH-1:DATA_WIDTH-4].
REQ-019 COLLECT + word matching latched channel: shift nibble in, count+1; on count=NIBBLES commit and return to IDLE.
REQ-020 COLLECT + word matching a different channel: pulse AssemblyError, discard partial data, restart assembly with this word as first nibble of the new channel.
REQ-021 COLLECT timer SHALL clear on every accepted word and increment otherwise; on reaching TIMEOUT_CYCLES pulse AssemblyError and return to IDLE with no commit.
REQ-022 Timeout and matching word in the same cycle: the word SHALL win (no error, timer cleared).
REQ-023 Commit latency: CommandOut and CommandValid SHALL update on the rising edge that samples the final word (visible the following cycle).
REQ-024 Level channel: CommandOut holds the committed value until the next commit.
REQ-025 Pulse channel: CommandOut equals committed value for exactly PULSE_CYCLES clocks, then returns to channel default.
REQ-026 Commit to a pulse channel while its pulse is active SHALL load the new value and restart the full PULSE_CYCLES count.
REQ-027 At most one channel SHALL commit per clock; CommandValid is one-hot or zero.

Reset
REQ-028 While reset_n=0: CommandOut = per-channel defaults, CommandValid=0, AssemblyError=0, state IDLE, count/timer/pulse counters 0.
REQ-029 Reset asserted mid-assembly or mid-pulse SHALL discard partial data and terminate the pulse with no strobe.
REQ-030 Reset deassertion SHALL cause no commit or strobe.

Structure
REQ-031 Shared package command_decoder_pkg SHALL hold address/payload field widths, assembler state enum, and channel-address function.
REQ-032 Per-channel output register with level/pulse behaviour and 8-bit pulse counter SHALL be sub-module command_channel, instantiated NUM_CHANNELS times.

Verification
REQ-033 NIBBLES=2, level ch1: words 16'hA015, 16'hA01C -> ch1 = 8'h5C, CommandValid=4'b0010 one cycle, held afterwards.
REQ-034 Pulse ch2, PULSE_CYCLES=3: commit 8'h7E -> ch2 = 8'h7E for 3 cycles, then default 8'hFF; recommit at cycle 2 extends to 3 cycles from recommit.
REQ-035 Interleave: 16'hA013 then 16'hA024 -> AssemblyError one cycle, ch1 unchanged; then 16'hA025 -> ch2 = 8'h45.
REQ-036 Timeout, TIMEOUT_CYCLES=10: 16'hA013, no word 10 cycles -> AssemblyError, no commit; word at exactly cycle 10 -> commit, no error.
REQ-037 Non-matching 16'hB015 between two nibbles -> ignored, commit proceeds; reset_n low after first nibble -> defaults, no strobe.
